fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined MIPS core; owns the fetch PC and sequences it against a handshaked instruction memory.
- Drives at most one outstanding IM request and delivers fetched instructions to the IF/ID boundary.
- Honours decode-stage stalls, branch/jump redirects and exception redirects, and discards stale responses.

---
 rtl/fetch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one IM request at a
// time, and presents fetched instructions (or misaligned-fetch faults) to
// decode while honouring stalls, branch redirects and exception redirects.
module fetch_ctrl #(
  parameter logic [31:0] PC_INIT   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // REQ: requesting (or presenting a fault), WAIT: request granted and
  // awaiting response, HOLD: response captured while decode is stalled.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic              fault_done_q, fault_done_d;

  logic              redir_take;
  logic [XLEN-1:0]   redir_pc;
  logic              pc_misaligned;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   hold_inc;
  logic              gnt_take;

  // Redirect resolution and PC arithmetic shared by both comb processes.
  always_comb begin
    redir_take    = exc_valid | redirect_valid;
    redir_pc      = exc_valid ? EXC_ENTRY : redirect_target;
    pc_misaligned = |pc_q[1:0];
    pc_inc        = pc_q + PC_STEP;
    hold_inc      = hold_pc_q + PC_STEP;
    gnt_take      = (state_q == ST_REQ) && !pc_misaligned && im_gnt;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_REQ;
      pc_q         <= PC_INIT;
      drop_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      fault_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      fault_done_q <= fault_done_d;
    end
  end

  // Next-state logic: redirects win over every sequential transition.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    fault_done_d = fault_done_q;

    case (state_q)
      ST_REQ: begin
        if (redir_take) begin
          pc_d         = redir_pc;
          fault_done_d = 1'b0;
          if (gnt_take) begin
            // Request already accepted at the old PC; its response is stale.
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (pc_misaligned) begin
          // Fault slot is consumed once; afterwards idle until redirected.
          if (!fault_done_q && !stall) begin
            fault_done_d = 1'b1;
          end
        end else if (gnt_take) begin
          drop_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redir_take) begin
          pc_d         = redir_pc;
          fault_done_d = 1'b0;
          if (im_rvalid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (im_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = im_rdata;
            state_d      = ST_HOLD;
          end else begin
            pc_d    = pc_inc;
            state_d = ST_REQ;
          end
        end
      end

      ST_HOLD: begin
        if (redir_take) begin
          pc_d         = redir_pc;
          fault_done_d = 1'b0;
          state_d      = ST_REQ;
        end else if (!stall) begin
          pc_d    = hold_inc;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Output decode; presentation is killed in any cycle a redirect arrives.
  always_comb begin
    im_req   = 1'b0;
    im_addr  = pc_q;
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    if_exc   = 1'b0;

    if (!reset) begin
      im_addr = PC_INIT;
    end else begin
      case (state_q)
        ST_REQ: begin
          im_req = !pc_misaligned;
          if (pc_misaligned && !fault_done_q && !redir_take) begin
            if_valid = 1'b1;
            if_exc   = 1'b1;
            if_pc    = pc_q;
          end
        end

        ST_WAIT: begin
          if (im_rvalid && !drop_q && !redir_take) begin
            if_valid = 1'b1;
            if_pc    = pc_q;
            if_instr = im_rdata;
          end
        end

        ST_HOLD: begin
          if (!redir_take) begin
            if_valid = 1'b1;
            if_pc    = hold_pc_q;
            if_instr = hold_instr_q;
          end
        end

        default: begin
          im_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level fetch model checks every
// cycle, and literal expectations pin the key points of each scenario.
module tb_fetch_ctrl;

  localparam logic [31:0] PC_INIT   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exc_valid = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc;

  fetch_ctrl #(
    .PC_INIT  (PC_INIT),
    .EXC_ENTRY(EXC_ENTRY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exc_valid      (exc_valid),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_gnt         (im_gnt),
    .im_rvalid      (im_rvalid),
    .im_rdata       (im_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_exc         (if_exc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory image: word at address a reads as {A5A5, a[15:0]}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  // Staged stimulus, applied at the next falling edge.
  logic        s_reset = 1'b0;
  logic        s_stall = 1'b0;
  logic        s_redir = 1'b0;
  logic        s_exc = 1'b0;
  logic [31:0] s_tgt = '0;
  logic        s_gnt_block = 1'b0;
  int          lat = 1;
  int          cyc_no = 0;
  int          pq_due[$];
  logic [31:0] pq_addr[$];

  // One cycle: apply inputs, play the memory (gnt same cycle, rvalid after lat).
  task automatic tick();
    @(negedge clk);
    reset           = s_reset;
    stall           = s_stall;
    redirect_valid  = s_redir;
    exc_valid       = s_exc;
    redirect_target = s_tgt;
    cyc_no++;
    if (pq_due.size() > 0 && pq_due[0] == cyc_no) begin
      im_rvalid = 1'b1;
      im_rdata  = mem_word(pq_addr[0]);
      pq_due.delete(0);
      pq_addr.delete(0);
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    im_gnt = im_req & ~s_gnt_block;
    if (im_gnt) begin
      pq_due.push_back(cyc_no + lat);
      pq_addr.push_back(im_addr);
    end
    #2;
  endtask

  task automatic exp_req(input string n, input logic [31:0] a);
    chk1({n, ".im_req"}, im_req, 1'b1);
    chk({n, ".im_addr"}, im_addr, a);
  endtask

  task automatic exp_valid(input string n, input logic [31:0] pc, input logic [31:0] ins);
    chk1({n, ".if_valid"}, if_valid, 1'b1);
    chk({n, ".if_pc"}, if_pc, pc);
    chk({n, ".if_instr"}, if_instr, ins);
    chk1({n, ".if_exc"}, if_exc, 1'b0);
  endtask

  // Transaction-level model: a fetch PC, at most one outstanding request
  // (possibly stale), at most one presented-but-unconsumed instruction, and
  // a flag for an already-reported misaligned fetch.
  logic [31:0] m_pc = PC_INIT;
  logic        m_busy = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_slot = 1'b0;
  logic [31:0] m_slot_pc = '0;
  logic [31:0] m_slot_instr = '0;
  logic        m_fault_taken = 1'b0;

  logic        e_req, e_v, e_exc, pres, p_exc, redir, chk_addr;
  logic [31:0] e_addr, e_pc, e_instr, p_pc, p_instr, tgt;

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    #3;
    redir    = exc_valid | redirect_valid;
    tgt      = exc_valid ? EXC_ENTRY : redirect_target;
    e_req    = 1'b0;
    e_addr   = m_pc;
    chk_addr = 1'b0;
    e_v      = 1'b0;
    e_pc     = '0;
    e_instr  = '0;
    e_exc    = 1'b0;
    pres     = 1'b0;
    p_exc    = 1'b0;
    p_pc     = '0;
    p_instr  = '0;

    if (!reset) begin
      e_addr   = PC_INIT;
      chk_addr = 1'b1;
    end else if (m_slot) begin
      pres = 1'b1; p_pc = m_slot_pc; p_instr = m_slot_instr;
    end else if (m_busy) begin
      if (im_rvalid && !m_stale) begin
        pres = 1'b1; p_pc = m_pc; p_instr = im_rdata;
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (!m_fault_taken) begin
        pres = 1'b1; p_pc = m_pc; p_instr = '0; p_exc = 1'b1;
      end
    end else begin
      e_req = 1'b1; e_addr = m_pc; chk_addr = 1'b1;
    end

    if (reset && pres && !redir) begin
      e_v = 1'b1; e_pc = p_pc; e_instr = p_instr; e_exc = p_exc;
    end

    chk1("model.im_req", im_req, e_req);
    chk1("model.if_valid", if_valid, e_v);
    chk1("model.if_exc", if_exc, e_exc);
    if (chk_addr) chk("model.im_addr", im_addr, e_addr);
    if (e_v || !reset) begin
      chk("model.if_pc", if_pc, e_pc);
      chk("model.if_instr", if_instr, e_instr);
    end

    if (!reset) begin
      m_pc = PC_INIT; m_busy = 1'b0; m_stale = 1'b0; m_slot = 1'b0; m_fault_taken = 1'b0;
    end else if (redir) begin
      m_pc = tgt; m_slot = 1'b0; m_fault_taken = 1'b0;
      if (m_busy && im_rvalid) begin
        m_busy = 1'b0; m_stale = 1'b0;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end else if (e_req && im_gnt) begin
        m_busy = 1'b1; m_stale = 1'b1;
      end
    end else if (m_slot) begin
      if (!stall) begin
        m_slot = 1'b0; m_pc = m_slot_pc + 32'd4;
      end
    end else if (m_busy) begin
      if (im_rvalid) begin
        m_busy = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (stall) begin
          m_slot = 1'b1; m_slot_pc = m_pc; m_slot_instr = im_rdata;
        end else m_pc = m_pc + 32'd4;
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (!m_fault_taken && !stall) m_fault_taken = 1'b1;
    end else if (im_gnt) begin
      m_busy = 1'b1; m_stale = 1'b0;
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    // Reset held for two cycles.
    tick(); tick();
    chk1("rst.im_req", im_req, 1'b0);
    chk("rst.im_addr", im_addr, PC_INIT);
    chk1("rst.if_valid", if_valid, 1'b0);

    // Zero-wait memory, no stall: one instruction every two cycles.
    s_reset = 1'b1;
    tick(); exp_req("seq.a0", 32'h0000_3000);
    tick(); exp_valid("seq.v0", 32'h0000_3000, 32'hA5A5_3000); chk1("seq.noreq", im_req, 1'b0);
    tick(); exp_req("seq.a1", 32'h0000_3004);
    tick(); exp_valid("seq.v1", 32'h0000_3004, 32'hA5A5_3004);
    tick(); exp_req("seq.a2", 32'h0000_3008);
    tick(); exp_valid("seq.v2", 32'h0000_3008, 32'hA5A5_3008);

    // Stall for three cycles as the 0x3004 response arrives.
    s_reset = 1'b0; tick(); s_reset = 1'b1;
    tick(); exp_req("stl.a0", 32'h0000_3000);
    tick(); exp_valid("stl.v0", 32'h0000_3000, 32'hA5A5_3000);
    tick(); exp_req("stl.a1", 32'h0000_3004);
    s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_valid("stl.held", 32'h0000_3004, 32'hA5A5_3004);
      chk1("stl.noreq", im_req, 1'b0);
    end
    s_stall = 1'b0;
    tick(); exp_valid("stl.release", 32'h0000_3004, 32'hA5A5_3004);
    tick(); exp_req("stl.next", 32'h0000_3008);

    // Redirect in the response cycle of 0x3008: response dropped.
    s_redir = 1'b1; s_tgt = 32'h0000_3100;
    tick(); chk1("rdr.killed", if_valid, 1'b0);
    s_redir = 1'b0;
    tick(); exp_req("rdr.next", 32'h0000_3100);
    tick(); exp_valid("rdr.v", 32'h0000_3100, 32'hA5A5_3100);

    // Redirect while waiting (two-cycle memory): stale response discarded.
    lat = 2;
    tick(); exp_req("drp.a", 32'h0000_3104);
    s_redir = 1'b1;
    tick(); chk1("drp.wait", if_valid, 1'b0);
    s_redir = 1'b0;
    tick(); chk1("drp.dropped", if_valid, 1'b0); chk1("drp.noreq", im_req, 1'b0);
    lat = 1; s_gnt_block = 1'b1;
    tick(); exp_req("drp.next", 32'h0000_3100);

    // Exception beats branch redirect while ungranted in REQ.
    s_exc = 1'b1; s_redir = 1'b1; s_tgt = 32'h0000_3200;
    tick(); exp_req("exc.same", 32'h0000_3100);
    s_exc = 1'b0; s_redir = 1'b0; s_gnt_block = 1'b0;
    tick(); exp_req("exc.next", 32'h0000_4180);

    // Misaligned target: fault slot, held under stall, then idle.
    s_redir = 1'b1; s_tgt = 32'h0000_3102;
    tick(); chk1("mis.killed", if_valid, 1'b0);
    s_redir = 1'b0; s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) s_stall = 1'b0;
      tick();
      chk1("mis.noreq", im_req, 1'b0);
      chk1("mis.valid", if_valid, 1'b1);
      chk1("mis.exc", if_exc, 1'b1);
      chk("mis.pc", if_pc, 32'h0000_3102);
      chk("mis.instr", if_instr, 32'h0);
      if (i == 2) s_stall = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick(); chk1("mis.idle_req", im_req, 1'b0); chk1("mis.idle_v", if_valid, 1'b0);
    end
    s_redir = 1'b1; s_tgt = 32'h0000_3000;
    tick(); chk1("mis.redir_v", if_valid, 1'b0);
    s_redir = 1'b0; lat = 2;
    tick(); exp_req("mis.next", 32'h0000_3000);

    // Reset while waiting; the late response arrives during reset.
    s_reset = 1'b0;
    tick(); chk1("rw.v0", if_valid, 1'b0); chk("rw.addr0", im_addr, PC_INIT);
    tick(); chk1("rw.v1", if_valid, 1'b0); chk("rw.pc1", if_pc, 32'h0);
    chk("rw.instr1", if_instr, 32'h0); chk1("rw.req1", im_req, 1'b0);
    s_reset = 1'b1; lat = 1;
    tick(); exp_req("rw.next", 32'h0000_3000);
    tick(); exp_valid("rw.v", 32'h0000_3000, 32'hA5A5_3000);

    // PC wrap from 0xFFFF_FFFC to 0.
    s_gnt_block = 1'b1;
    tick(); exp_req("wrp.a0", 32'h0000_3004);
    s_redir = 1'b1; s_tgt = 32'hFFFF_FFFC;
    tick();
    s_redir = 1'b0; s_gnt_block = 1'b0;
    tick(); exp_req("wrp.top", 32'hFFFF_FFFC);
    tick(); exp_valid("wrp.v", 32'hFFFF_FFFC, 32'hA5A5_FFFC);
    tick(); exp_req("wrp.zero", 32'h0000_0000);

    // Redirect while holding under stall discards the held instruction.
    s_stall = 1'b1;
    tick(); exp_valid("hld.v", 32'h0000_0000, 32'hA5A5_0000);
    s_redir = 1'b1; s_tgt = 32'h0000_3300;
    tick(); chk1("hld.killed", if_valid, 1'b0);
    s_redir = 1'b0; s_stall = 1'b0;
    tick(); exp_req("hld.next", 32'h0000_3300);
    tick(); exp_valid("hld.v2", 32'h0000_3300, 32'hA5A5_3300);
    tick(); tick();

    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net in case the run never reaches its end.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
